// File: rtl/gpu_pkg.sv
// Shared mini-GPU definitions: core pipeline state encodings, LSU state encodings
// and default datapath widths.
package gpu_pkg;

  localparam int GPU_ADDR_W = 8;
  localparam int GPU_DATA_W = 8;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: sequences one LDR/STR per instruction in step with the core.
// Define LSU_TIMEOUT_EN to add a WAITING watchdog that forces DONE and flags lsu_timeout.
module lsu
  import gpu_pkg::*;
#(
  parameter int ADDR_W = GPU_ADDR_W,
  parameter int DATA_W = GPU_DATA_W
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic              mem_read_ready,
  input  logic              mem_write_ready,
  input  logic [2:0]        core_state,
  input  logic [ADDR_W-1:0] rs_out,
  input  logic [DATA_W-1:0] rt_out,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] lsu_out,
`ifdef LSU_TIMEOUT_EN
  output logic              lsu_timeout,
`endif
  output logic [1:0]        lsu_state
);

  lsu_state_e        state_q;
  logic              op_load_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] out_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  assign lsu_timeout = timeout_q;
`endif

  // The operation type is latched at the request edge so the ready input of the
  // other type can be ignored for the rest of the transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= LSU_IDLE;
      op_load_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      out_q     <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else if (!enable) begin
      state_q   <= LSU_IDLE;
`ifdef LSU_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST && (mem_read_enable || mem_write_enable)) begin
            state_q   <= LSU_REQUESTING;
            op_load_q <= mem_read_enable;
          end
        end
        LSU_REQUESTING: begin
          if (op_load_q) begin
            rd_addr_q <= rs_out;
          end else begin
            wr_addr_q <= rs_out;
            wr_data_q <= rt_out;
          end
          state_q <= LSU_WAITING;
`ifdef LSU_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        LSU_WAITING: begin
          if (op_load_q && mem_read_ready) begin
            out_q   <= mem_read_data;
            state_q <= LSU_DONE;
          end else if (!op_load_q && mem_write_ready) begin
            state_q <= LSU_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= LSU_DONE;
            timeout_q <= 1'b1;
            if (op_load_q) out_q <= '1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE) begin
            state_q   <= LSU_IDLE;
`ifdef LSU_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign lsu_state         = state_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_out           = out_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu: a driver pushes the expected DONE-time
// outputs, a monitor pops and compares whenever the unit enters DONE.
module tb_lsu;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       mem_read_enable, mem_write_enable;
  logic       mem_read_ready, mem_write_ready;
  logic [2:0] core_state;
  logic [7:0] rs_out, rt_out, mem_read_data;
  logic [7:0] mem_read_address, mem_write_address, mem_write_data, lsu_out;
  logic [1:0] lsu_state;
  logic       tmo;

  lsu #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
    .core_state(core_state), .rs_out(rs_out), .rt_out(rt_out),
    .mem_read_data(mem_read_data), .mem_read_address(mem_read_address),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .lsu_out(lsu_out),
`ifdef LSU_TIMEOUT_EN
    .lsu_timeout(tmo),
`endif
    .lsu_state(lsu_state)
  );

`ifndef LSU_TIMEOUT_EN
  assign tmo = 1'b0;
`endif

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] raddr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] out;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  exp_t mdl;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".raddr"}, {24'd0, mem_read_address}, {24'd0, mdl.raddr});
    chk({tag, ".waddr"}, {24'd0, mem_write_address}, {24'd0, mdl.waddr});
    chk({tag, ".wdata"}, {24'd0, mem_write_data}, {24'd0, mdl.wdata});
    chk({tag, ".out"}, {24'd0, lsu_out}, {24'd0, mdl.out});
  endtask

  // Monitor: compare against the scoreboard on every entry into DONE.
  logic [1:0] prev_state = 2'd0;
  always @(negedge clock) begin
    if (reset) begin
      prev_state <= 2'd0;
    end else begin
      if (lsu_state == 2'd3 && prev_state != 2'd3) begin
        if (exp_q.size() == 0) begin
          chk("mon.unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mon.raddr", {24'd0, mem_read_address}, {24'd0, e.raddr});
          chk("mon.waddr", {24'd0, mem_write_address}, {24'd0, e.waddr});
          chk("mon.wdata", {24'd0, mem_write_data}, {24'd0, e.wdata});
          chk("mon.out", {24'd0, lsu_out}, {24'd0, e.out});
`ifdef LSU_TIMEOUT_EN
          chk("mon.timeout", {31'd0, tmo}, {31'd0, e.timeout});
`endif
        end
      end
      prev_state <= lsu_state;
    end
  end

  // One instruction: REQUEST, EXECUTE while memory stalls, ready, then UPDATE.
  task automatic do_txn(input bit ld, input bit st, input int stall, input bit force_tmo);
    logic [7:0] rs, rt, d;
    bit         is_ld;
    exp_t       e;
    rs = 8'($urandom);
    rt = 8'($urandom);
    is_ld = ld;
    enable = 1'b1;
    mem_read_enable = ld;
    mem_write_enable = st;
    rs_out = rs;
    rt_out = rt;
    core_state = 3'b011;
    step();
    chk("txn.requesting", {30'd0, lsu_state}, 32'd1);
    core_state = 3'b101;
    step();
    chk("txn.waiting", {30'd0, lsu_state}, 32'd2);
    if (is_ld) mdl.raddr = rs;
    else begin
      mdl.waddr = rs;
      mdl.wdata = rt;
    end
    rs_out = 8'($urandom);
    rt_out = 8'($urandom);
    for (int i = 0; i < stall; i++) begin
      mem_read_data = 8'($urandom);
      if (is_ld) mem_write_ready = 1'($urandom);
      else mem_read_ready = 1'($urandom);
      step();
      chk("txn.stall", {30'd0, lsu_state}, 32'd2);
    end
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    if (force_tmo) begin
      for (int i = 0; i < 15; i++) begin
        step();
        chk("tmo.still_waiting", {30'd0, lsu_state}, 32'd2);
      end
      if (is_ld) mdl.out = 8'hFF;
      e = mdl;
      e.timeout = 1'b1;
      exp_q.push_back(e);
      step();
    end else begin
      d = 8'($urandom);
      mem_read_data = d;
      if (is_ld) begin
        mem_read_ready = 1'b1;
        mdl.out = d;
      end else begin
        mem_write_ready = 1'b1;
      end
      e = mdl;
      e.timeout = 1'b0;
      exp_q.push_back(e);
      step();
      mem_read_ready = 1'b0;
      mem_write_ready = 1'b0;
    end
    chk("txn.done", {30'd0, lsu_state}, 32'd3);
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      core_state = 3'b101;
      step();
      chk("txn.done_hold", {30'd0, lsu_state}, 32'd3);
    end
    core_state = 3'b110;
    step();
    core_state = 3'b000;
    chk("txn.idle", {30'd0, lsu_state}, 32'd0);
`ifdef LSU_TIMEOUT_EN
    chk("txn.timeout_clear", {31'd0, tmo}, 32'd0);
`endif
    chk_outputs("txn.held");
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    mem_read_enable = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    core_state = 3'b000;
    rs_out = 8'h0;
    rt_out = 8'h0;
    mem_read_data = 8'h0;
    mdl = '0;
    step();
    reset = 1'b0;
    chk("reset.state", {30'd0, lsu_state}, 32'd0);
    chk_outputs("reset");

    // Directed load and store from the bring-up sequence, then both enables.
    do_txn(1'b1, 1'b0, 0, 1'b0);
    do_txn(1'b0, 1'b1, 0, 1'b0);
    do_txn(1'b1, 1'b0, 5, 1'b0);
    do_txn(1'b1, 1'b1, 2, 1'b0);

    // Disabled thread ignores REQUEST.
    enable = 1'b0;
    mem_read_enable = 1'b1;
    core_state = 3'b011;
    rs_out = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("disabled.idle", {30'd0, lsu_state}, 32'd0);
    end
    chk_outputs("disabled");
    core_state = 3'b000;

    // No operation decoded: stays idle even with REQUEST.
    enable = 1'b1;
    mem_read_enable = 1'b0;
    mem_write_enable = 1'b0;
    core_state = 3'b011;
    step();
    chk("noop.idle", {30'd0, lsu_state}, 32'd0);
    core_state = 3'b000;

    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      do_txn(sel != 1, sel != 0, int'($urandom_range(0, 6)), 1'b0);
    end

`ifdef LSU_TIMEOUT_EN
    do_txn(1'b1, 1'b0, 0, 1'b1);
    do_txn(1'b0, 1'b1, 0, 1'b1);
    do_txn(1'b1, 1'b0, 3, 1'b0);
`endif

    // Reset while WAITING aborts and clears everything.
    enable = 1'b1;
    mem_read_enable = 1'b1;
    mem_write_enable = 1'b0;
    core_state = 3'b011;
    step();
    core_state = 3'b101;
    step();
    chk("abort.waiting", {30'd0, lsu_state}, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mdl = '0;
    chk("abort.state", {30'd0, lsu_state}, 32'd0);
    chk_outputs("abort");
    mem_read_ready = 1'b1;
    core_state = 3'b000;
    step();
    chk("abort.stays_idle", {30'd0, lsu_state}, 32'd0);
    mem_read_ready = 1'b0;

    do_txn(1'b0, 1'b1, 1, 1'b0);
    step();
    chk("scoreboard.drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Per-thread load/store unit for the mini-GPU core. One instance sits beside each thread's ALU and register file.
- Sequences one memory load (LDR) or store (STR) per instruction, synchronised to the core's pipeline state.
- Drives the data-memory address/data buses, captures load data into `lsu_out`, and reports progress via `lsu_state` so the core scheduler can stall until DONE.

Parameters:
- ADDR_W, 8, memory address width (address comes from `rs_out`).
- DATA_W, 8, data width (`rt_out`, `mem_read_data`, `lsu_out`).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  thread active; when 0 the unit holds IDLE and ignores requests
- mem_read_enable  in  1  decoded LDR
- mem_write_enable  in  1  decoded STR
- mem_read_ready  in  1  memory has returned `mem_read_data` this cycle
- mem_write_ready  in  1  memory has accepted the write this cycle
- core_state  in  3  core pipeline state; REQUEST=3'b011, UPDATE=3'b110
- rs_out  in  ADDR_W  address operand
- rt_out  in  DATA_W  store data operand
- mem_read_data  in  DATA_W  load data from memory
- mem_read_address  out  ADDR_W  registered load address
- mem_write_address  out  ADDR_W  registered store address
- mem_write_data  out  DATA_W  registered store data
- lsu_out  out  DATA_W  registered load result, written back to the register file in UPDATE
- lsu_state  out  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3

Behaviour:
- All outputs are registers. On reset every output is 0 and `lsu_state` is IDLE.
- Reset mid-transaction aborts the transaction and returns to IDLE with all outputs 0.
- Active operation = `mem_read_enable` (load), else `mem_write_enable` (store). Read wins if both are set. If neither is set, the state machine stays IDLE.
- When `enable`=0 the state is held at IDLE and all outputs hold their values.
- IDLE → REQUESTING: at a rising edge where `core_state`==REQUEST and an operation is enabled.
- REQUESTING → WAITING: unconditionally one cycle later.
  - Load: on that edge, `mem_read_address` <= `rs_out`.
  - Store: on that edge, `mem_write_address` <= `rs_out` and `mem_write_data` <= `rt_out`.
  - The memory interface treats `lsu_state`==WAITING as the request-valid qualifier.
- WAITING → DONE, load: on the edge where `mem_read_ready`=1; same edge `lsu_out` <= `mem_read_data`.
- WAITING → DONE, store: on the edge where `mem_write_ready`=1.
- WAITING with no ready asserted: stay in WAITING indefinitely.
- The ready input not matching the operation type is ignored.
- DONE → IDLE: on the edge where `core_state`==UPDATE. Otherwise stay in DONE.
- `lsu_out`, `mem_*_address` and `mem_write_data` hold their values until overwritten by a later transaction; they are not cleared on DONE→IDLE.
- Minimum latency from REQUEST edge to DONE: 3 edges (REQUESTING, WAITING, DONE with ready already high).

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 16) and an internal counter cleared on entry to WAITING.
  - If the counter reaches TIMEOUT_CYCLES with no matching ready, force DONE.
  - Loads that time out set `lsu_out` = all-ones (8'hFF).
  - Adds output `lsu_timeout` (1 bit), set on a forced DONE and cleared on return to IDLE.
- Undefined: no counter and no `lsu_timeout` port; WAITING can last forever.

Decomposition:
- Shared package `gpu_pkg`:
  - core_state encodings (IDLE..UPDATE, REQUEST=3'b011, UPDATE=3'b110)
  - LSU state encodings IDLE/REQUESTING/WAITING/DONE
  - ADDR_W/DATA_W defaults
- Single flat module; no sub-module needed. The timeout counter is inline.

Test Plan:
- Reset: assert reset 1 cycle → `lsu_state`=0 and all address/data/`lsu_out` outputs 0.
- Load: `enable`=1, `mem_read_enable`=1, `rs_out`=8'h0A, `mem_read_data`=8'hAB, `core_state`=3'b011 for 1 cycle, then 3'b101 for 1 cycle, then `mem_read_ready` pulsed for 1 cycle, then `core_state`=3'b110 → `mem_read_address`=8'h0A, `lsu_out`=8'hAB, `lsu_state` back to 0.
- Store: `mem_write_enable`=1, `rs_out`=8'h0C, `rt_out`=8'h55, same sequence with `mem_write_ready` → `mem_write_address`=8'h0C, `mem_write_data`=8'h55, values held after IDLE.
- Stall: load with `mem_read_ready` held low 5 cycles → `lsu_state` stays 2. Ready then asserted → DONE next edge. DONE holds until `core_state`=3'b110.
- Enable/priority:
  - `enable`=0 with REQUEST → stays IDLE.
  - Both enables set → load path taken (only `mem_read_address` updates).
- LSU_TIMEOUT_EN: no ready for 16 cycles in WAITING → DONE, `lsu_out`=8'hFF, `lsu_timeout`=1, cleared after UPDATE.
